// File: rtl/bec_pkg.sv
// Shared widths, FSM state encoding and fault codes for the BEC key sequencer.
package bec_pkg;

   localparam int unsigned BEC_KEY_W   = 163;
   localparam int unsigned BEC_TMO_CYC = 1024;
   localparam int unsigned BEC_CNT_W   = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOADED = 3'd1,
      ST_RUN    = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_DONE   = 3'd4,
      ST_ERR    = 3'd5
   } bec_state_e;

   typedef enum logic [1:0] {
      ERR_NONE       = 2'b00,
      ERR_TIMEOUT    = 2'b01,
      ERR_EARLY_DONE = 2'b10,
      ERR_LATE_KEY   = 2'b11
   } bec_err_e;

endpackage

// File: rtl/bec_key_sequencer_if.sv
// Handshake between the key sequencer (master) and the BEC datapath (slave).
interface bec_key_sequencer_if;

   logic master_ena_proc;
   logic ki;
   logic next_key;
   logic slv_done;

   modport master (
      output master_ena_proc,
      output ki,
      input  next_key,
      input  slv_done
   );

   modport slave (
      input  master_ena_proc,
      input  ki,
      output next_key,
      output slv_done
   );

endinterface

// File: rtl/bec_watchdog.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count would reach TMO_CYC-1.
module bec_watchdog #(
   parameter int unsigned TMO_CYC = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CW = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;

   logic [CW-1:0] r_cnt;

   // Idle counter; any handshake event or leaving RUN/DRAIN restarts it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr || !en) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // Fires so the FSM takes ERR on the same edge the count hits TMO_CYC-1.
   assign expired = en && !clr && (r_cnt == CW'(TMO_CYC - 2));

endmodule

// File: rtl/bec_key_sequencer.sv
// Presents a scalar key LSB-first to the BEC, one bit per next_key pulse,
// and supervises the run for early completion, late requests and stalls.
module bec_key_sequencer
   import bec_pkg::*;
#(
   parameter int unsigned KEY_W   = BEC_KEY_W,
   parameter int unsigned TMO_CYC = BEC_TMO_CYC
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic                 key_load,
   input  logic [KEY_W-1:0]     key_in,
   input  logic                 start,
   input  logic                 abort,
   bec_key_sequencer_if.master  bec,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [1:0]           err_code,
   output logic [BEC_CNT_W-1:0] bit_cnt
);

   localparam int unsigned CNT_W = BEC_CNT_W;

   bec_state_e       r_state;
   logic [KEY_W-1:0] r_key;
   logic [CNT_W-1:0] r_bit_cnt;
   logic             r_ena;
   logic             r_ki;
   logic             r_busy;
   logic             r_done;
   logic             r_err;
   bec_err_e         r_err_code;

   logic             w_wd_clr;
   logic             w_wd_en;
   logic             w_wd_expired;
   logic             w_early_done;
   logic             w_last_bit;
   logic [CNT_W-1:0] w_bit_cnt_inc;

   assign w_wd_clr      = start || bec.next_key || bec.slv_done;
   assign w_wd_en       = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   assign w_early_done  = r_bit_cnt < CNT_W'(KEY_W - 1);
   assign w_last_bit    = r_bit_cnt == CNT_W'(KEY_W - 1);
   assign w_bit_cnt_inc = (r_bit_cnt == CNT_W'(KEY_W)) ? r_bit_cnt : r_bit_cnt + CNT_W'(1);

   bec_watchdog #(
      .TMO_CYC (TMO_CYC)
   ) u_watchdog (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .clr     (w_wd_clr),
      .en      (w_wd_en),
      .expired (w_wd_expired)
   );

   // Sequencer FSM; every output is registered alongside the state.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state    <= ST_IDLE;
         r_key      <= '0;
         r_bit_cnt  <= '0;
         r_ena      <= 1'b0;
         r_ki       <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= ERR_NONE;
      end else if (abort) begin
         r_state   <= ST_IDLE;
         r_key     <= '0;
         r_bit_cnt <= '0;
         r_ena     <= 1'b0;
         r_ki      <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_LOADED, ST_DONE, ST_ERR: begin
               if (key_load) begin
                  r_state    <= ST_LOADED;
                  r_key      <= key_in;
                  r_bit_cnt  <= '0;
                  r_done     <= 1'b0;
                  r_err      <= 1'b0;
                  r_err_code <= ERR_NONE;
               end else if (start && (r_state == ST_LOADED)) begin
                  r_state <= ST_RUN;
                  r_ena   <= 1'b1;
                  r_busy  <= 1'b1;
                  r_ki    <= r_key[0];
               end
            end
            ST_RUN: begin
               if (bec.slv_done && w_early_done) begin
                  r_state    <= ST_ERR;
                  r_ena      <= 1'b0;
                  r_ki       <= 1'b0;
                  r_busy     <= 1'b0;
                  r_err      <= 1'b1;
                  r_err_code <= ERR_EARLY_DONE;
               end else if (bec.next_key) begin
                  r_key     <= r_key >> 1;
                  r_bit_cnt <= w_bit_cnt_inc;
                  if (w_last_bit) begin
                     r_ki <= 1'b0;
                     if (bec.slv_done) begin
                        r_state <= ST_DONE;
                        r_ena   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end else begin
                        r_state <= ST_DRAIN;
                     end
                  end else begin
                     r_ki <= r_key[1];
                  end
               end else if (w_wd_expired) begin
                  r_state    <= ST_ERR;
                  r_ena      <= 1'b0;
                  r_ki       <= 1'b0;
                  r_busy     <= 1'b0;
                  r_err      <= 1'b1;
                  r_err_code <= ERR_TIMEOUT;
               end
            end
            ST_DRAIN: begin
               if (bec.next_key) begin
                  r_state    <= ST_ERR;
                  r_ena      <= 1'b0;
                  r_busy     <= 1'b0;
                  r_err      <= 1'b1;
                  r_err_code <= ERR_LATE_KEY;
               end else if (bec.slv_done) begin
                  r_state <= ST_DONE;
                  r_ena   <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else if (w_wd_expired) begin
                  r_state    <= ST_ERR;
                  r_ena      <= 1'b0;
                  r_busy     <= 1'b0;
                  r_err      <= 1'b1;
                  r_err_code <= ERR_TIMEOUT;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_ena   <= 1'b0;
               r_ki    <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_err   <= 1'b0;
            end
         endcase
      end
   end

   assign bec.master_ena_proc = r_ena;
   assign bec.ki              = r_ki;
   assign busy                = r_busy;
   assign done                = r_done;
   assign err                 = r_err;
   assign err_code            = r_err_code;
   assign bit_cnt             = r_bit_cnt;

endmodule

// File: tb/tb_bec_key_sequencer.sv
// Bench for bec_key_sequencer: directed scenarios plus randomized runs, all
// checked every cycle against a bit-index reference model of the sequencer.
module tb_bec_key_sequencer;

   localparam int KEY_W   = 163;
   localparam int TMO_CYC = 1024;

   localparam int M_IDLE   = 0;
   localparam int M_LOADED = 1;
   localparam int M_RUN    = 2;
   localparam int M_DRAIN  = 3;
   localparam int M_DONE   = 4;
   localparam int M_ERR    = 5;

   logic             wb_clk_i;
   logic             wb_rst_i;
   logic             key_load;
   logic [KEY_W-1:0] key_in;
   logic             start;
   logic             abort;
   logic             busy;
   logic             done;
   logic             err;
   logic [1:0]       err_code;
   logic [7:0]       bit_cnt;

   bec_key_sequencer_if bec_if ();

   bec_key_sequencer #(
      .KEY_W   (KEY_W),
      .TMO_CYC (TMO_CYC)
   ) dut (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .key_load (key_load),
      .key_in   (key_in),
      .start    (start),
      .abort    (abort),
      .bec      (bec_if),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .err_code (err_code),
      .bit_cnt  (bit_cnt)
   );

   initial begin
      wb_clk_i = 1'b0;
      forever #5 wb_clk_i = ~wb_clk_i;
   end

   // Reference model: the loaded key is kept intact and indexed by the count.
   int               m_mode;
   int               m_cnt;
   int               m_code;
   int               m_idle;
   logic [KEY_W-1:0] m_key;
   logic             mdl_valid = 1'b0;
   logic             saw_drain = 1'b0;

   // Literal expectations queued by the stimulus thread, checked by the compare thread.
   string       lit_name [256];
   logic [31:0] lit_act  [256];
   logic [31:0] lit_exp  [256];
   int          lit_wi = 0;
   int          lit_ri = 0;

   int n_checks = 0;
   int n_errors = 0;

   task automatic model_reset();
      m_mode = M_IDLE;
      m_cnt  = 0;
      m_code = 0;
      m_idle = 0;
      m_key  = '0;
   endtask

   task automatic idle_tick();
      m_idle++;
      if (m_idle == TMO_CYC - 1) begin
         m_mode = M_ERR;
         m_code = 1;
      end
   endtask

   task automatic model_step();
      if (wb_rst_i) begin
         model_reset();
      end else if (abort) begin
         m_mode = M_IDLE;
         m_cnt  = 0;
         m_key  = '0;
      end else begin
         case (m_mode)
            M_RUN: begin
               if (bec_if.slv_done && m_cnt < KEY_W - 1) begin
                  m_mode = M_ERR;
                  m_code = 2;
               end else if (bec_if.next_key) begin
                  m_cnt++;
                  m_idle = 0;
                  if (m_cnt == KEY_W) m_mode = bec_if.slv_done ? M_DONE : M_DRAIN;
               end else if (bec_if.slv_done || start) begin
                  m_idle = 0;
               end else begin
                  idle_tick();
               end
            end
            M_DRAIN: begin
               if (bec_if.next_key) begin
                  m_mode = M_ERR;
                  m_code = 3;
               end else if (bec_if.slv_done) begin
                  m_mode = M_DONE;
               end else if (start) begin
                  m_idle = 0;
               end else begin
                  idle_tick();
               end
            end
            default: begin
               if (key_load) begin
                  m_key  = key_in;
                  m_cnt  = 0;
                  m_code = 0;
                  m_mode = M_LOADED;
               end else if (start && m_mode == M_LOADED) begin
                  m_mode = M_RUN;
                  m_idle = 0;
               end
            end
         endcase
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Compare thread: DUT outputs against the model every cycle, then queued literals.
   always @(negedge wb_clk_i) begin
      if (mdl_valid) begin
         chk("master_ena_proc", 32'(bec_if.master_ena_proc), 32'(m_mode == M_RUN || m_mode == M_DRAIN));
         chk("busy", 32'(busy), 32'(m_mode == M_RUN || m_mode == M_DRAIN));
         chk("ki", 32'(bec_if.ki), (m_mode == M_RUN) ? 32'(m_key[m_cnt]) : 32'd0);
         chk("done", 32'(done), 32'(m_mode == M_DONE));
         chk("err", 32'(err), 32'(m_mode == M_ERR));
         chk("err_code", 32'(err_code), 32'(m_code));
         chk("bit_cnt", 32'(bit_cnt), 32'(m_cnt));
      end
      while (lit_ri < lit_wi) begin
         chk(lit_name[lit_ri], lit_act[lit_ri], lit_exp[lit_ri]);
         lit_ri++;
      end
   end

   task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
      if (lit_wi < 256) begin
         lit_name[lit_wi] = nm;
         lit_act[lit_wi]  = act;
         lit_exp[lit_wi]  = exp;
         lit_wi++;
      end
   endtask

   // One clock: apply strobes, advance the model past the edge, release strobes.
   task automatic cyc(input logic kl, input logic st, input logic ab, input logic nk, input logic sd);
      key_load        = kl;
      start           = st;
      abort           = ab;
      bec_if.next_key = nk;
      bec_if.slv_done = sd;
      @(posedge wb_clk_i);
      #1;
      model_step();
      key_load        = 1'b0;
      start           = 1'b0;
      abort           = 1'b0;
      bec_if.next_key = 1'b0;
      bec_if.slv_done = 1'b0;
      if (busy && bit_cnt == 8'(KEY_W)) saw_drain = 1'b1;
   endtask

   task automatic rand_key(output logic [KEY_W-1:0] k);
      k = '0;
      for (int i = 0; i < KEY_W; i++) k[i] = 1'($urandom_range(0, 1));
   endtask

   task automatic load_start(input logic [KEY_W-1:0] k);
      key_in = k;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      end
   endtask

   // Randomized run: 0 drain/done, 1 final bit with slv_done, 2 early slv_done,
   // 3 abort mid-run, 4 late next_key in drain; stray key_load/start sprinkled in.
   task automatic random_run();
      logic [KEY_W-1:0] k;
      int               flavor;
      int               tgt;
      int               steps;
      logic             kl, st, ab, nk, sd;
      rand_key(k);
      flavor = $urandom_range(0, 4);
      tgt    = $urandom_range(0, KEY_W - 2);
      load_start(k);
      steps = 0;
      while ((m_mode == M_RUN || m_mode == M_DRAIN) && steps < 3000) begin
         kl = 1'b0; st = 1'b0; ab = 1'b0; nk = 1'b0; sd = 1'b0;
         if (m_mode == M_RUN) begin
            nk = ($urandom_range(0, 2) != 0);
            if (flavor == 1 && nk && m_cnt == KEY_W - 1) sd = 1'b1;
            if (flavor == 2 && m_cnt == tgt) sd = 1'b1;
            if (flavor == 3 && m_cnt == tgt) ab = 1'b1;
            if ($urandom_range(0, 99) == 0) begin
               kl     = 1'b1;
               key_in = ~key_in;
            end
            if ($urandom_range(0, 99) == 0) st = 1'b1;
         end else if ($urandom_range(0, 2) == 0) begin
            if (flavor == 4) nk = 1'b1;
            else sd = 1'b1;
         end
         cyc(kl, st, ab, nk, sd);
         steps++;
      end
      if (m_mode == M_RUN || m_mode == M_DRAIN) lit("run cycle bound", 32'd1, 32'd0);
      repeat ($urandom_range(1, 3)) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [KEY_W-1:0] k1;
      logic [KEY_W-1:0] k2;
      wb_rst_i        = 1'b1;
      key_load        = 1'b0;
      key_in          = '0;
      start           = 1'b0;
      abort           = 1'b0;
      bec_if.next_key = 1'b0;
      bec_if.slv_done = 1'b0;
      model_reset();
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      mdl_valid = 1'b1;

      // Reset state.
      lit("reset ena", 32'(bec_if.master_ena_proc), 32'd0);
      lit("reset busy", 32'(busy), 32'd0);
      lit("reset err_code", 32'(err_code), 32'd0);
      lit("reset bit_cnt", 32'(bit_cnt), 32'd0);
      @(negedge wb_clk_i);
      #1 wb_rst_i = 1'b0;

      // start without a loaded key is ignored.
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      lit("start from idle busy", 32'(busy), 32'd0);

      // Key 5: ki 1,0,1,0,... then DRAIN and DONE.
      load_start(KEY_W'(5));
      lit("key5 first ki", 32'(bec_if.ki), 32'd1);
      lit("key5 ena", 32'(bec_if.master_ena_proc), 32'd1);
      for (int i = 0; i < KEY_W; i++) begin
         repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         if (i < 4) lit("key5 ki seq", 32'(bec_if.ki), (i == 1) ? 32'd1 : 32'd0);
      end
      lit("key5 drain bit_cnt", 32'(bit_cnt), 32'd163);
      lit("key5 drain ena", 32'(bec_if.master_ena_proc), 32'd1);
      lit("key5 drain ki", 32'(bec_if.ki), 32'd0);
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      lit("key5 done", 32'(done), 32'd1);
      lit("key5 done ena", 32'(bec_if.master_ena_proc), 32'd0);
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      lit("key5 done persists", 32'(done), 32'd1);

      // Early slv_done after 10 bits.
      rand_key(k1);
      load_start(k1);
      pulses(10);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      lit("early err", 32'(err), 32'd1);
      lit("early err_code", 32'(err_code), 32'd2);
      lit("early bit_cnt", 32'(bit_cnt), 32'd10);
      lit("early ena", 32'(bec_if.master_ena_proc), 32'd0);

      // Watchdog: error lands on the 1023rd idle cycle.
      load_start(k1);
      repeat (TMO_CYC - 2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      lit("tmo not yet", 32'(err), 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      lit("tmo err", 32'(err), 32'd1);
      lit("tmo err_code", 32'(err_code), 32'd1);

      // Final next_key together with slv_done skips DRAIN.
      rand_key(k1);
      load_start(k1);
      pulses(KEY_W - 1);
      saw_drain = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      lit("direct done", 32'(done), 32'd1);
      lit("direct bit_cnt", 32'(bit_cnt), 32'd163);
      lit("direct no drain", 32'(saw_drain), 32'd0);

      // Abort at bit 50, then a fresh key.
      rand_key(k1);
      load_start(k1);
      pulses(50);
      lit("abort pre bit_cnt", 32'(bit_cnt), 32'd50);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      lit("abort busy", 32'(busy), 32'd0);
      lit("abort bit_cnt", 32'(bit_cnt), 32'd0);
      rand_key(k2);
      k2[0] = ~k1[50];
      load_start(k2);
      lit("reload busy", 32'(busy), 32'd1);
      lit("reload bit_cnt", 32'(bit_cnt), 32'd0);
      lit("reload ki", 32'(bec_if.ki), 32'(k2[0]));

      // Asynchronous reset mid-run.
      pulses(20);
      #2 wb_rst_i = 1'b1;
      model_reset();
      #1;
      lit("async rst ena", 32'(bec_if.master_ena_proc), 32'd0);
      lit("async rst busy", 32'(busy), 32'd0);
      lit("async rst bit_cnt", 32'(bit_cnt), 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge wb_clk_i);
      #1 wb_rst_i = 1'b0;
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      lit("post rst start ignored", 32'(busy), 32'd0);

      for (int r = 0; r < 25; r++) random_run();

      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
